// File: rtl/e203_tb_pkg.sv
// Shared definitions for the end-of-test commit monitor: state encoding and
// default end-of-test parameters.
package e203_tb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [31:0] TOHOST_PC_DEF   = 32'h8000_0086;
    localparam int unsigned END_HITS_DEF    = 32'd8;
    localparam int unsigned TIMEOUT_CYC_DEF = 32'd10_000_000;

endpackage

// File: rtl/e203_tb_sat_cnt.sv
// Saturating up-counter with synchronous clear and a freeze input that holds
// the value regardless of inc.
module e203_tb_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         freeze,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: clear wins over freeze, freeze wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (!freeze && inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/e203_tb_commit_monitor.sv
// Passive end-of-test monitor: counts cycles, issued instructions and tohost
// commits, and decides when the test ends and whether it passed.
module e203_tb_commit_monitor
    import e203_tb_pkg::*;
#(
    parameter int                 PC_SIZE     = 32,
    parameter int                 XLEN        = 32,
    parameter logic [PC_SIZE-1:0] TOHOST_PC   = PC_SIZE'(TOHOST_PC_DEF),
    parameter int unsigned        END_HITS    = END_HITS_DEF,
    parameter int unsigned        TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic               exu_i_valid,
    input  logic               exu_i_ready,
    input  logic               irq_busy,
    input  logic [XLEN-1:0]    x3_val,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt,
    output logic [7:0]         tohost_hits,
    output logic [31:0]        end_cycle,
    output logic               done,
    output logic               pass,
    output logic               timeout
);

    localparam logic [7:0]      LAST_HIT_CNT = 8'(END_HITS - 32'd1);
    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYC - 32'd1);
    localparam logic [XLEN-1:0] X3_PASS      = {{(XLEN-1){1'b0}}, 1'b1};

    state_t      state_r;
    logic        first_hit_r;
    logic [31:0] end_cycle_r;
    logic        done_r;
    logic        pass_r;
    logic        timeout_r;

    logic        hit_s;
    logic        frozen_s;
    logic        instr_inc_s;
    logic        last_hit_s;
    logic        timeout_now_s;
    logic        drain_req_s;

    // cmt_valid gates the PC compare so an undriven PC cannot create a hit.
    assign hit_s         = cmt_valid & (cmt_pc == TOHOST_PC);
    assign frozen_s      = (state_r == ST_DONE);
    assign instr_inc_s   = exu_i_valid & exu_i_ready & ~first_hit_r;
    assign last_hit_s    = (state_r == ST_RUN) & hit_s & (tohost_hits == LAST_HIT_CNT);
    assign timeout_now_s = (cycle_cnt == TIMEOUT_LAST);
    assign drain_req_s   = (state_r == ST_DRAIN) | last_hit_s;

    e203_tb_sat_cnt #(.W(32)) u_cycle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (1'b1),
        .freeze (frozen_s),
        .cnt    (cycle_cnt)
    );

    e203_tb_sat_cnt #(.W(32)) u_instr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (instr_inc_s),
        .freeze (frozen_s),
        .cnt    (instr_cnt)
    );

    e203_tb_sat_cnt #(.W(8)) u_hit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (hit_s),
        .freeze (frozen_s),
        .cnt    (tohost_hits)
    );

    // End-of-test FSM with registered verdict and first-hit capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            first_hit_r <= 1'b0;
            end_cycle_r <= 32'd0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN, ST_DRAIN: begin
                    if (hit_s && !first_hit_r) begin
                        first_hit_r <= 1'b1;
                        end_cycle_r <= cycle_cnt;
                    end
                    // The cycle budget overrides any end condition in the same cycle.
                    if (timeout_now_s) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end else if (drain_req_s && !irq_busy) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        pass_r  <= (x3_val == X3_PASS);
                    end else if (drain_req_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign end_cycle = end_cycle_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_e203_tb_commit_monitor.sv
// Bench for e203_tb_commit_monitor: table-driven scenarios, random runs against
// a cycle-level reference model, and an asynchronous reset sequence.
module tb_e203_tb_commit_monitor;

    localparam logic [31:0] TOHOST  = 32'h8000_0086;
    localparam int unsigned N_END   = 8;
    localparam int unsigned TMO_A   = 10_000_000;
    localparam int unsigned TMO_B   = 100;
    localparam int          RUN_LEN = 150;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = 32'd0;
    logic        exu_i_valid = 1'b0;
    logic        exu_i_ready = 1'b0;
    logic        irq_busy = 1'b0;
    logic [31:0] x3_val = 32'd0;

    logic [31:0] o_cyc   [2];
    logic [31:0] o_instr [2];
    logic [7:0]  o_hits  [2];
    logic [31:0] o_end   [2];
    logic        o_done  [2];
    logic        o_pass  [2];
    logic        o_to    [2];

    always #5 clk = ~clk;

    e203_tb_commit_monitor #(.TIMEOUT_CYC(TMO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .exu_i_valid(exu_i_valid), .exu_i_ready(exu_i_ready), .irq_busy(irq_busy),
        .x3_val(x3_val), .cycle_cnt(o_cyc[0]), .instr_cnt(o_instr[0]),
        .tohost_hits(o_hits[0]), .end_cycle(o_end[0]), .done(o_done[0]),
        .pass(o_pass[0]), .timeout(o_to[0])
    );

    e203_tb_commit_monitor #(.TIMEOUT_CYC(TMO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .exu_i_valid(exu_i_valid), .exu_i_ready(exu_i_ready), .irq_busy(irq_busy),
        .x3_val(x3_val), .cycle_cnt(o_cyc[1]), .instr_cnt(o_instr[1]),
        .tohost_hits(o_hits[1]), .end_cycle(o_end[1]), .done(o_done[1]),
        .pass(o_pass[1]), .timeout(o_to[1])
    );

    // Reference model state: what the monitor should report after each edge.
    typedef struct {
        int unsigned cyc;
        int unsigned instr;
        int unsigned hits;
        int unsigned endc;
        bit          seen;
        bit          drain;
        bit          fin;
        bit          pass;
        bit          to;
    } mdl_t;

    typedef struct {
        int sel;
        int first, gap, nhit, irq_until, x3, hs_n;
        int exp_done;
        bit exp_pass, exp_to;
        int exp_end, exp_cyc, exp_hits, exp_instr;
    } scn_t;

    mdl_t m [2];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned tmo_of(input int i);
        return (i == 0) ? TMO_A : TMO_B;
    endfunction

    // One clock cycle of the test-end rules applied to the model.
    function automatic mdl_t mstep(input mdl_t s, input int unsigned tmo, input bit v,
                                   input logic [31:0] pc, input bit hs, input bit irq,
                                   input logic [31:0] x3);
        mdl_t n;
        bit   hit;
        bit   reached;
        n = s;
        if (s.fin) return s;
        hit = v && (pc == TOHOST);
        if (hs && !s.seen && s.instr != 32'hFFFF_FFFF) n.instr = s.instr + 1;
        if (hit && !s.seen) begin
            n.seen = 1'b1;
            n.endc = s.cyc;
        end
        if (hit && s.hits < 255) n.hits = s.hits + 1;
        reached = s.drain || (hit && (s.hits + 1 == N_END));
        if (s.cyc == tmo - 1) begin
            n.fin = 1'b1;
            n.to  = 1'b1;
            n.pass = 1'b0;
        end else if (reached && !irq) begin
            n.fin  = 1'b1;
            n.pass = (x3 == 32'd1);
        end else if (reached) begin
            n.drain = 1'b1;
        end
        if (s.cyc != 32'hFFFF_FFFF) n.cyc = s.cyc + 1;
        return n;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s[%0d] cycle_cnt", tag, i), o_cyc[i], m[i].cyc);
            chk($sformatf("%s[%0d] instr_cnt", tag, i), o_instr[i], m[i].instr);
            chk($sformatf("%s[%0d] tohost_hits", tag, i), {24'd0, o_hits[i]}, m[i].hits);
            chk($sformatf("%s[%0d] end_cycle", tag, i), o_end[i], m[i].endc);
            chk($sformatf("%s[%0d] done", tag, i), {31'd0, o_done[i]}, {31'd0, m[i].fin});
            chk($sformatf("%s[%0d] pass", tag, i), {31'd0, o_pass[i]}, {31'd0, m[i].fin & m[i].pass});
            chk($sformatf("%s[%0d] timeout", tag, i), {31'd0, o_to[i]}, {31'd0, m[i].to});
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), step models, compare after the edge.
    task automatic apply(input bit v, input logic [31:0] pc, input bit iv, input bit ir,
                         input bit irq, input logic [31:0] x3);
        cmt_valid   = v;
        cmt_pc      = pc;
        exu_i_valid = iv;
        exu_i_ready = ir;
        irq_busy    = irq;
        x3_val      = x3;
        for (int i = 0; i < 2; i++) m[i] = mstep(m[i], tmo_of(i), v, pc, iv && ir, irq, x3);
        @(negedge clk);
        check_all("cycle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmt_valid = 1'b0;
        exu_i_valid = 1'b0;
        exu_i_ready = 1'b0;
        irq_busy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
        check_all("reset");
        rst_n = 1'b1;
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        int          done_at;
        bit          hit;
        bit          v;
        logic [31:0] pc;
        bit          iv;
        bit          ir;
        do_reset();
        done_at = -1;
        for (int c = 0; c < RUN_LEN; c++) begin
            hit = (s.nhit > 0) && (c >= s.first) && ((c - s.first) % s.gap == 0) &&
                  ((c - s.first) / s.gap < s.nhit);
            if (hit) begin
                v = 1'b1; pc = TOHOST;
            end else begin
                case (c % 4)
                    1:       begin v = 1'b1; pc = 32'h8000_0088; end
                    2:       begin v = 1'b0; pc = TOHOST; end
                    default: begin v = 1'b0; pc = $urandom; end
                endcase
            end
            iv = (c < s.hs_n) || (c % 3 == 0);
            ir = (c < s.hs_n) || (c % 3 == 1);
            apply(v, pc, iv, ir, c < s.irq_until, 32'(s.x3));
            if (done_at < 0 && o_done[s.sel]) done_at = c + 1;
        end
        chk($sformatf("scn%0d done_cycle", idx), 32'(done_at), 32'(s.exp_done));
        chk($sformatf("scn%0d pass", idx), {31'd0, o_pass[s.sel]}, {31'd0, s.exp_pass});
        chk($sformatf("scn%0d timeout", idx), {31'd0, o_to[s.sel]}, {31'd0, s.exp_to});
        chk($sformatf("scn%0d end_cycle", idx), o_end[s.sel], 32'(s.exp_end));
        chk($sformatf("scn%0d cycle_cnt", idx), o_cyc[s.sel], 32'(s.exp_cyc));
        chk($sformatf("scn%0d tohost_hits", idx), {24'd0, o_hits[s.sel]}, 32'(s.exp_hits));
        chk($sformatf("scn%0d instr_cnt", idx), o_instr[s.sel], 32'(s.exp_instr));
    endtask

    scn_t tbl [7];

    initial begin
        //          sel first gap nhit irq  x3 hs  done pass to end cyc hits instr
        tbl[0] = '{0,  20,  10,  8,   0,  1,  0,  91, 1'b1, 1'b0, 20, 91,  8,  0};
        tbl[1] = '{0,  20,  10,  8, 120,  1,  0, 121, 1'b1, 1'b0, 20, 121, 8,  0};
        tbl[2] = '{0,  20,  10,  8,   0,  3,  0,  91, 1'b0, 1'b0, 20, 91,  8,  0};
        tbl[3] = '{1,   0,  10,  0,   0,  1,  0, 100, 1'b0, 1'b1,  0, 100, 0,  0};
        tbl[4] = '{1,  29,  10,  8,   0,  1,  0, 100, 1'b0, 1'b1, 29, 100, 8,  0};
        tbl[5] = '{0,  49,   5,  8,   0,  1, 80,  85, 1'b1, 1'b0, 49, 85,  8, 50};
        tbl[6] = '{0,  20,  10, 12, 115,  1,  0, 116, 1'b1, 1'b0, 20, 116, 10, 0};

        for (int i = 0; i < 7; i++) run_scn(i, tbl[i]);

        // Randomized runs: sparse tohost commits, random handshakes and IRQ activity.
        for (int r = 0; r < 6; r++) begin
            int          p_hit;
            int          irq_rel;
            logic [31:0] x3r;
            logic [31:0] pc;
            do_reset();
            p_hit   = $urandom_range(4, 20);
            irq_rel = $urandom_range(0, 200);
            x3r     = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'($urandom_range(0, 4));
            for (int c = 0; c < 220; c++) begin
                if ($urandom_range(0, 99) < p_hit) pc = TOHOST;
                else if ($urandom_range(0, 1) == 1) pc = 32'h8000_0088;
                else pc = $urandom;
                apply($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      (c < irq_rel) && ($urandom_range(0, 3) != 0), x3r);
            end
        end

        // Async reset while dut_a is draining, then a full passing sequence again.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            bit hit;
            hit = (c >= 20) && ((c - 20) % 10 == 0) && (c <= 90);
            apply(hit, hit ? TOHOST : 32'h0000_1000, 1'b1, 1'b1, 1'b1, 32'd1);
        end
        chk("async pre drain hits", {24'd0, o_hits[0]}, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
        check_all("async");
        run_scn(7, tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
